sram_dump_uart_tx: RTL

//  Reads a block of 16-bit words from external SRAM through the sram_ctrl request port and

---
 rtl/sram_dump_uart_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sram_dump_uart_tx.sv
// sram_dump_uart_tx: reads a block of 16-bit words from SRAM through the
// sram_ctrl request port and sends each word as two UART 8N1 bytes on txd,
// low byte first. All outputs are registered; txd idles high.
module sram_dump_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RD_WAIT      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dump_start,
  input  logic [18:0] start_addr,
  input  logic [19:0] word_count,
  output logic        sram_dump_selec,
  output logic        sram_dump_read,
  output logic        sram_dump_write,
  output logic [18:0] sram_dump_addr,
  input  logic [15:0] sram_dump_data,
  output logic        txd,
  output logic        busy,
  output logic        dump_done,
  output logic [19:0] dump_count
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int RW = $clog2(RD_WAIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LO, S_HI, S_NEXT, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [18:0]   addr_q, addr_d;
  logic [19:0]   remaining_q, remaining_d;
  logic [19:0]   count_q, count_d;
  logic [15:0]   word_q, word_d;
  logic [RW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          selec_q, selec_d;

  // State and output registers; reset forces txd high at once, abandoning any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      word_q      <= '0;
      rd_cnt_q    <= '0;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      selec_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      word_q      <= word_d;
      rd_cnt_q    <= rd_cnt_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      selec_q     <= selec_d;
    end
  end

  // Next-state logic: read a word, shift out its two frames, advance, repeat.
  always_comb begin
    logic [7:0] tx_byte;
    logic [9:0] frame;
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    word_d      = word_q;
    rd_cnt_d    = rd_cnt_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    txd_d       = 1'b1;
    tx_byte     = (state_q == S_HI) ? word_q[15:8] : word_q[7:0];
    frame       = {1'b1, tx_byte, 1'b0};

    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          addr_d      = start_addr;
          remaining_d = word_count;
          count_d     = '0;
          rd_cnt_d    = '0;
          state_d     = (word_count == 20'd0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        // Address has been held RD_WAIT cycles by the last one; capture data then.
        if (rd_cnt_q == RW'(RD_WAIT - 1)) begin
          word_d    = sram_dump_data;
          rd_cnt_d  = '0;
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_LO;
        end else begin
          rd_cnt_d = rd_cnt_q + RW'(1);
        end
      end
      S_LO, S_HI: begin
        // txd_q lags one cycle, so the HI start bit lands right after the LO stop bit.
        txd_d = frame[bit_idx_q];
        if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 4'd9) begin
            bit_idx_d = '0;
            state_d   = (state_q == S_LO) ? S_HI : S_NEXT;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        count_d     = count_q + 20'd1;
        remaining_d = remaining_q - 20'd1;
        addr_d      = addr_q + 19'd1;
        rd_cnt_d    = '0;
        state_d     = (remaining_q == 20'd1) ? S_FIN : S_RD;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered status outputs follow the next state so they align with state_q.
    selec_d = (state_d == S_RD);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
  end

  assign sram_dump_selec = selec_q;
  assign sram_dump_read  = selec_q;
  assign sram_dump_write = 1'b0;
  assign sram_dump_addr  = addr_q;
  assign txd             = txd_q;
  assign busy            = busy_q;
  assign dump_done       = done_q;
  assign dump_count      = count_q;

endmodule
